// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - data-memory request/response bus between core and responder
interface dmem_responder_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        err;

    modport master (output req, we, addr, wdata, input rdata, ready, err);
    modport slave  (input req, we, addr, wdata, output rdata, ready, err);
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - word RAM plus LED/switch/cycle-counter I/O window behind a req/ready handshake
module dmem_responder #(
    parameter int          DEPTH_WORDS = 64,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] IO_BASE     = 32'h0000_1000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    dmem_responder_if.slave  bus,
    input  logic [9:0]       i_sw_in,
    output logic [9:0]       o_led_out
);
    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  LAST_WAIT = 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      r_state, w_next;
    logic [3:0]  r_wait_cnt;
    logic        r_we;
    logic [31:0] r_addr, r_wdata, r_rdata, r_cycle;
    logic        r_err;
    logic [9:0]  r_led, r_sw_meta, r_sw_sync;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic        w_we, w_enter_resp, w_commit;
    logic [31:0] w_addr, w_wdata, w_rd_val;
    logic        w_misal, w_ram, w_led, w_sw, w_cyc, w_err;

    // A zero-wait build enters RESP on the accept edge, so decode the live bus while IDLE.
    assign w_we    = (r_state == S_IDLE) ? bus.we    : r_we;
    assign w_addr  = (r_state == S_IDLE) ? bus.addr  : r_addr;
    assign w_wdata = (r_state == S_IDLE) ? bus.wdata : r_wdata;

    assign w_misal = |w_addr[1:0];
    assign w_ram   = !w_misal && (w_addr < RAM_BYTES);
    assign w_led   = (w_addr == IO_BASE);
    assign w_sw    = (w_addr == IO_BASE + 32'd4);
    assign w_cyc   = (w_addr == IO_BASE + 32'd8);
    assign w_err   = w_misal || !(w_ram || w_led || w_sw || w_cyc);

    assign w_enter_resp = (w_next == S_RESP) && (r_state != S_RESP);
    assign w_commit     = w_enter_resp && w_we && !w_err;

    always_comb begin
        w_rd_val = '0;
        if (w_ram)      w_rd_val = r_mem[w_addr[AW+1:2]];
        else if (w_led) w_rd_val = {22'b0, r_led};
        else if (w_sw)  w_rd_val = {22'b0, r_sw_sync};
        else if (w_cyc) w_rd_val = r_cycle;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.req) w_next = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
            S_WAIT:  if (r_wait_cnt == LAST_WAIT) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            r_led      <= '0;
            r_cycle    <= '0;
            r_sw_meta  <= '0;
            r_sw_sync  <= '0;
        end else begin
            r_state   <= w_next;
            r_sw_meta <= i_sw_in;
            r_sw_sync <= r_sw_meta;
            r_cycle   <= (w_commit && w_cyc) ? w_wdata : r_cycle + 32'd1;
            if (r_state == S_IDLE && bus.req) begin
                r_we       <= bus.we;
                r_addr     <= bus.addr;
                r_wdata    <= bus.wdata;
                r_wait_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_wait_cnt <= r_wait_cnt + 4'd1;
            end
            if (w_enter_resp) begin
                r_err   <= w_err;
                r_rdata <= (w_we || w_err) ? '0 : w_rd_val;
            end
            if (w_commit && w_led) r_led <= w_wdata[9:0];
            // RAM is not cleared by reset; it sits here only so reset blocks a pending write.
            if (w_commit && w_ram) r_mem[w_addr[AW+1:2]] <= w_wdata;
        end
    end

    assign bus.ready = (r_state == S_RESP);
    assign bus.err   = bus.ready && r_err;
    assign bus.rdata = bus.ready ? r_rdata : '0;
    assign o_led_out = r_led;
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench for dmem_responder (1-wait and 0-wait builds)
module tb_dmem_responder;
    localparam logic [31:0] IO = 32'h0000_1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_edge = 0;
    always @(posedge clk) n_edge <= n_edge + 1;

    logic        req, we, sel;
    logic [31:0] addr, wdata;
    logic [9:0]  sw_in, led_a, led_b;

    dmem_responder_if bus_a ();
    dmem_responder_if bus_b ();

    assign bus_a.req   = req && !sel;
    assign bus_a.we    = we;
    assign bus_a.addr  = addr;
    assign bus_a.wdata = wdata;
    assign bus_b.req   = req && sel;
    assign bus_b.we    = we;
    assign bus_b.addr  = addr;
    assign bus_b.wdata = wdata;

    dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(1), .IO_BASE(IO)) u_dut_a (
        .i_clk(clk), .i_rst(rst), .bus(bus_a), .i_sw_in(sw_in), .o_led_out(led_a));
    dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(0), .IO_BASE(IO)) u_dut_b (
        .i_clk(clk), .i_rst(rst), .bus(bus_b), .i_sw_in(sw_in), .o_led_out(led_b));

    logic        ready_o, err_o;
    logic [31:0] rdata_o;
    assign ready_o = sel ? bus_b.ready : bus_a.ready;
    assign err_o   = sel ? bus_b.err   : bus_a.err;
    assign rdata_o = sel ? bus_b.rdata : bus_a.rdata;

    // reference model state, index 0 = one-wait build, 1 = zero-wait build
    logic [31:0] m_mem [2][64];
    bit          m_val [2][64];
    logic [9:0]  m_led [2];
    logic [9:0]  m_sw;
    logic [31:0] cyc_val [2];
    int          cyc_edge [2];
    bit          prev_keep = 1'b0;
    bit          prev_sel  = 1'b0;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic model(input bit d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                         input int e, output bit xerr, output logic [31:0] xrd, output bit chk);
        xerr = 1'b0;
        xrd  = '0;
        chk  = !w;
        if (a[1:0] != 2'b00) begin
            xerr = 1'b1; chk = 1'b1;
        end else if (a < 32'd256) begin
            if (w) begin m_mem[d][a[7:2]] = wd; m_val[d][a[7:2]] = 1'b1; end
            else begin xrd = m_mem[d][a[7:2]]; chk = m_val[d][a[7:2]]; end
        end else if (a == IO) begin
            if (w) m_led[d] = wd[9:0];
            else   xrd = {22'b0, m_led[d]};
        end else if (a == IO + 32'd4) begin
            if (!w) xrd = {22'b0, m_sw};
        end else if (a == IO + 32'd8) begin
            // counter read returns its value just before the response-entry edge
            if (w) begin cyc_val[d] = wd; cyc_edge[d] = e; end
            else   xrd = cyc_val[d] + 32'(e - 1 - cyc_edge[d]);
        end else begin
            xerr = 1'b1; chk = 1'b1;
        end
    endtask

    task automatic txn(input bit d, input bit w, input logic [31:0] a, input logic [31:0] wd, input bit keep);
        int ws, lat, e;
        bit xerr, chk;
        logic [31:0] xrd;
        ws  = d ? 0 : 1;
        lat = (prev_keep && prev_sel == d) ? ws + 2 : ws + 1;
        sel = d; req = 1'b1; we = w; addr = a; wdata = wd;
        for (int k = 1; k < lat; k++) begin
            @(negedge clk);
            check("idle_ready", {31'b0, ready_o}, 32'd0);
            check("idle_rdata", rdata_o, 32'd0);
            check("idle_err", {31'b0, err_o}, 32'd0);
            if (!keep && k >= lat - ws) begin
                req = 1'b0; addr = $urandom; wdata = $urandom; we = 1'($urandom);
            end
        end
        @(negedge clk);
        check("latency", {31'b0, ready_o}, 32'd1);
        for (int t = 0; t < 20 && ready_o !== 1'b1; t++) @(negedge clk);
        e = n_edge;
        model(d, w, a, wd, e, xerr, xrd, chk);
        check("err", {31'b0, err_o}, {31'b0, xerr});
        if (chk) check("rdata", rdata_o, xrd);
        check("led", {22'b0, d ? led_b : led_a}, {22'b0, m_led[d]});
        if (!keep) begin
            req = 1'b0; addr = $urandom; wdata = $urandom; we = 1'($urandom);
            @(negedge clk);
            check("pulse", {31'b0, ready_o}, 32'd0);
        end
        prev_keep = keep;
        prev_sel  = d;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            m_led[d] = '0; cyc_val[d] = '0; cyc_edge[d] = n_edge;
        end
        prev_keep = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic set_sw(input logic [9:0] v);
        sw_in = v; m_sw = v;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        bit d, w, keep;
        logic [31:0] a;
        req = 1'b0; we = 1'b0; addr = '0; wdata = '0; sel = 1'b0; sw_in = '0; m_sw = '0;
        do_reset();
        check("rst_ready_a", {31'b0, bus_a.ready}, 32'd0);
        check("rst_rdata_a", bus_a.rdata, 32'd0);
        check("rst_err_a", {31'b0, bus_a.err}, 32'd0);
        check("rst_led_a", {22'b0, led_a}, 32'd0);
        check("rst_ready_b", {31'b0, bus_b.ready}, 32'd0);
        check("rst_led_b", {22'b0, led_b}, 32'd0);

        txn(0, 1, 32'h10, 32'hDEADBEEF, 0);
        txn(0, 0, 32'h10, 32'h0, 0);
        txn(0, 1, 32'h13, 32'h1234_5678, 0);
        txn(0, 0, 32'h10, 32'h0, 0);
        txn(0, 1, IO, 32'hFFFF_F2A5, 0);
        check("led_2a5", {22'b0, led_a}, 32'h2A5);
        txn(0, 0, IO, 32'h0, 0);
        txn(0, 0, 32'h2000, 32'h0, 0);
        set_sw(10'h155);
        txn(0, 0, IO + 32'd4, 32'h0, 0);
        txn(0, 1, IO + 32'd4, 32'hFFFF_FFFF, 0);
        txn(0, 0, IO + 32'd4, 32'h0, 0);
        txn(0, 1, IO + 32'd8, 32'hFFFF_FFFE, 0);
        repeat (3) @(negedge clk);
        txn(0, 0, IO + 32'd8, 32'h0, 0);
        txn(0, 0, 32'h10, 32'h0, 1);
        txn(0, 0, 32'h10, 32'h0, 0);

        txn(0, 1, 32'h20, 32'hCAFE_0020, 0);
        sel = 1'b0; req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h1111_1111;
        @(negedge clk);
        req = 1'b0;
        check("wait_ready", {31'b0, bus_a.ready}, 32'd0);
        check("pre_rst_led", {22'b0, led_a}, {22'b0, m_led[0]});
        rst = 1'b1;
        #1;
        check("mid_rst_ready", {31'b0, bus_a.ready}, 32'd0);
        check("mid_rst_rdata", bus_a.rdata, 32'd0);
        check("mid_rst_err", {31'b0, bus_a.err}, 32'd0);
        check("mid_rst_led", {22'b0, led_a}, 32'd0);
        do_reset();
        txn(0, 0, 32'h20, 32'h0, 0);

        txn(1, 1, 32'h20, 32'h5A5A_0001, 0);
        txn(1, 0, 32'h20, 32'h0, 0);
        txn(1, 0, 32'h20, 32'h0, 1);
        txn(1, 1, IO + 32'd8, 32'hFFFF_FFFF, 1);
        txn(1, 0, IO + 32'd8, 32'h0, 0);

        for (int i = 0; i < 200; i++) begin
            d = 1'($urandom);
            w = 1'($urandom);
            case ($urandom_range(0, 7))
                0, 1, 2: a = 32'($urandom_range(0, 63)) << 2;
                3:       a = (32'($urandom_range(0, 63)) << 2) + 32'($urandom_range(1, 3));
                4:       a = IO;
                5:       a = IO + 32'd4;
                6:       a = IO + 32'd8;
                default: a = ($urandom_range(0, 1) != 0) ? 32'd256 : IO + 32'(4 * $urandom_range(3, 64));
            endcase
            keep = (i != 199) && ($urandom_range(0, 5) == 0);
            if (!prev_keep && $urandom_range(0, 15) == 0) set_sw(10'($urandom));
            txn(d, w, a, $urandom, keep);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
